// File: rtl/turn_controller.sv
// Turn sequencer for the two-player game: arbitrates button and new-game pulses,
// issues one board command at a time over valid/ack, and owns the turn bit and turn timer.
module turn_controller #(
   parameter int TURN_TICKS = 40,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic [4:0]       btn,
   input  logic             blue_new_req,
   input  logic             red_new_req,
   input  logic             cmd_ack,
   input  logic             move_legal,
   input  logic             win,
   output logic             cmd_valid,
   output logic [2:0]       cmd_code,
   output logic             turn,
   output logic [CNT_W-1:0] time_left,
   output logic             timeout,
   output logic             game_over,
   output logic [2:0]       fsm_state
);

   // Handshake: cmd_valid is high for every cycle spent in ISSUE with cmd_code held
   // stable; the command is consumed on the posedge where cmd_ack=1 and cmd_valid
   // drops on the following cycle. cmd_ack is ignored while cmd_valid=0.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLAY   = 3'd1,
      S_ISSUE  = 3'd2,
      S_CHECK  = 3'd3,
      S_SWITCH = 3'd4,
      S_TOUT   = 3'd5,
      S_OVER   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(TURN_TICKS);
   localparam logic [2:0]       C_NONE     = 3'd0;
   localparam logic [2:0]       C_UP       = 3'd1;
   localparam logic [2:0]       C_DOWN     = 3'd2;
   localparam logic [2:0]       C_LEFT     = 3'd3;
   localparam logic [2:0]       C_RIGHT    = 3'd4;
   localparam logic [2:0]       C_PLACE    = 3'd5;
   localparam logic [2:0]       C_NEW_BLUE = 3'd6;
   localparam logic [2:0]       C_NEW_RED  = 3'd7;

   state_t           r_state,      w_state_nxt;
   logic [2:0]       r_code,       w_code_nxt;
   logic             r_pend_valid, w_pend_valid_nxt;
   logic [2:0]       r_pend_code,  w_pend_code_nxt;
   logic             r_turn,       w_turn_nxt;
   logic [CNT_W-1:0] r_time,       w_time_nxt;

   logic [2:0]       w_new_code;
   logic [2:0]       w_btn_code;
   logic             w_expire;

   // Priority: red new > blue new > decision > up > down > left > right
   always_comb begin
      w_new_code = C_NONE;
      if (red_new_req)       w_new_code = C_NEW_RED;
      else if (blue_new_req) w_new_code = C_NEW_BLUE;
   end

   always_comb begin
      w_btn_code = C_NONE;
      if (btn[4])      w_btn_code = C_PLACE;
      else if (btn[3]) w_btn_code = C_UP;
      else if (btn[2]) w_btn_code = C_DOWN;
      else if (btn[1]) w_btn_code = C_LEFT;
      else if (btn[0]) w_btn_code = C_RIGHT;
   end

   assign w_expire = tick && (r_time == CNT_W'(1));

   always_comb begin
      w_state_nxt      = r_state;
      w_code_nxt       = r_code;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_code_nxt  = r_pend_code;
      w_turn_nxt       = r_turn;
      w_time_nxt       = r_time;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_new_code != C_NONE) begin
               w_code_nxt  = w_new_code;
               w_state_nxt = S_ISSUE;
            end
         end
         S_PLAY: begin
            if (tick) w_time_nxt = r_time - CNT_W'(1);
            if (w_new_code != C_NONE) begin
               w_code_nxt  = w_new_code;
               w_state_nxt = S_ISSUE;
            end else if (w_expire) begin
               w_state_nxt = S_TOUT;
            end else if (w_btn_code != C_NONE) begin
               w_code_nxt  = w_btn_code;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_new_code != C_NONE) begin
               w_pend_valid_nxt = 1'b1;
               w_pend_code_nxt  = w_new_code;
            end
            if (cmd_ack) begin
               // A new game requested during the handshake replaces whatever follows it
               if (r_pend_valid || (w_new_code != C_NONE)) begin
                  w_code_nxt       = (w_new_code != C_NONE) ? w_new_code : r_pend_code;
                  w_pend_valid_nxt = 1'b0;
               end else if (r_code == C_PLACE) begin
                  w_state_nxt = S_CHECK;
               end else if (r_code == C_NEW_BLUE || r_code == C_NEW_RED) begin
                  w_turn_nxt  = r_code[0];
                  w_time_nxt  = RELOAD;
                  w_state_nxt = S_PLAY;
               end else begin
                  w_state_nxt = S_PLAY;
               end
            end
         end
         S_CHECK: begin
            if (win)             w_state_nxt = S_OVER;
            else if (move_legal) w_state_nxt = S_SWITCH;
            else                 w_state_nxt = S_PLAY;
         end
         S_SWITCH, S_TOUT: begin
            w_turn_nxt  = ~r_turn;
            w_time_nxt  = RELOAD;
            w_state_nxt = S_PLAY;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_code       <= C_NONE;
         r_pend_valid <= 1'b0;
         r_pend_code  <= C_NONE;
         r_turn       <= 1'b0;
         r_time       <= RELOAD;
      end else begin
         r_state      <= w_state_nxt;
         r_code       <= w_code_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_code  <= w_pend_code_nxt;
         r_turn       <= w_turn_nxt;
         r_time       <= w_time_nxt;
      end
   end

   assign cmd_valid = (r_state == S_ISSUE);
   assign cmd_code  = cmd_valid ? r_code : C_NONE;
   assign turn      = r_turn;
   assign time_left = r_time;
   assign timeout   = (r_state == S_TOUT);
   assign game_over = (r_state == S_OVER);
   assign fsm_state = r_state;

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Sequences the two-player game datapath. Accepts debounced one-cycle button pulses and issues at most one command at a time to the board state-transition block through a valid/ack handshake. Owns the blue/red turn bit, a per-turn countdown clocked by the 4 Hz tick, legality and win checks after each placement, and game-over and new-game handling. It sits between the debounce/encoder stage and the state-transition, LED and 7-seg blocks.

Parameters:
TURN_TICKS, 40, ticks allowed per turn (40 ticks = 10 s at 4 Hz); valid range 1..2^CNT_W-1
CNT_W, 6, width of the turn timer

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide enable pulse at 4 Hz
btn  input  5  one-cycle pulses {decision, up, down, left, right}, bit4..bit0
blue_new_req  input  1  pulse: new game, blue moves first
red_new_req  input  1  pulse: new game, red moves first
cmd_ack  input  1  board accepted the current command
move_legal  input  1  board flag: last placement legal; valid in CHECK
win  input  1  board flag: last placement ended the game; valid in CHECK
cmd_valid  output  1  command present
cmd_code  output  3  0 none, 1 up, 2 down, 3 left, 4 right, 5 place, 6 clear-blue, 7 clear-red
turn  output  1  0 blue, 1 red
time_left  output  CNT_W  remaining ticks in the current turn
timeout  output  1  one-cycle pulse when a turn expires
game_over  output  1  high in OVER
fsm_state  output  3  encoded state, for debug and LEDs

Behaviour:
- Reset (async, reset_n=0): state IDLE, cmd_valid=0, cmd_code=0, turn=0, time_left=TURN_TICKS, timeout=0, game_over=0, pending-new latch cleared. Reset mid-handshake drops the command.
- State encoding: IDLE=0, PLAY=1, ISSUE=2, CHECK=3, SWITCH=4, TOUT=5, OVER=6.
- Input priority when pulses coincide in one cycle: red_new_req > blue_new_req > decision > up > down > left > right. Only the highest-priority pulse is used. The others are dropped.
- IDLE: ignores btn. A new-game request loads cmd_code 6 or 7 and goes to ISSUE.
- PLAY: timer runs. On tick, time_left decrements. If tick arrives with time_left==1: time_left becomes 0 and the FSM goes to TOUT. If a btn pulse and the expiring tick coincide, the timeout wins and the button is dropped. Otherwise the first button pulse loads codes 1..5 and goes to ISSUE. A new-game request loads 6 or 7 and goes to ISSUE.
- ISSUE: cmd_valid=1. cmd_code stays stable until the posedge where cmd_ack=1; cmd_valid drops the next cycle. Zero-wait ack gives cmd_valid high exactly 1 cycle. Timer is frozen. btn pulses are dropped. A new-game request is latched as pending (latest request wins).
- ISSUE on ack:
  - code 5 goes to CHECK.
  - codes 1..4 go to PLAY.
  - codes 6 and 7 set turn to 0 or 1 respectively, reload time_left, clear game_over, and go to PLAY.
  - If a request is pending, the FSM instead loads its code, stays in ISSUE, and clears the latch.
- CHECK (1 cycle): samples win and move_legal.
  - win=1 goes to OVER, regardless of legality.
  - else legal goes to SWITCH.
  - else goes to PLAY with turn and timer unchanged.
- SWITCH (1 cycle): turn toggles, time_left reloads to TURN_TICKS, next state PLAY.
- TOUT (1 cycle): timeout=1, turn toggles, time_left reloads, next state PLAY.
- OVER: game_over=1, btn ignored, timer frozen. Only a new-game request exits, via ISSUE.
- time_left never wraps: it is only decremented in PLAY, and PLAY leaves at 0.
- cmd_code reads 0 whenever cmd_valid=0.

Test Plan:
- Reset, then blue_new_req, ack after 3 cycles -> cmd_valid high 3 cycles with code 6; then PLAY, turn=0, time_left=40.
- In PLAY, up pulse with ack on the first ISSUE cycle -> cmd_code 1 for 1 cycle; turn unchanged; timer frozen during ISSUE.
- decision with move_legal=1, win=0 -> code 5, CHECK, SWITCH; turn toggles to 1; time_left=40. Repeat with move_legal=0 -> turn stays 0; time_left keeps its prior value.
- No input for 40 ticks -> timeout pulses on the cycle after the 40th tick; turn toggles; time_left=40. Same-cycle right pulse on the 40th tick -> no command issued.
- decision with win=1 -> game_over=1. Subsequent up/decision issue no cmd_valid. red_new_req -> code 7, turn=1, game_over=0.
- Simultaneous up+left pulse -> code 1 only. During ISSUE (ack held low), blue_new_req then red_new_req -> after ack, code 7 is issued next; reset_n low mid-ISSUE -> all outputs return to reset values immediately.
